// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// writeback-source encoding and the memory-wait FSM state type.
package pipe_pkg;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // EX-stage writeback source; WB_MEM marks a load
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_e;

  // True when a producer destination is a real register (x0 is never a
  // dependency) and matches the consumer source.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard signals. The pipeline (master) drives the
// stage register fields and consumes the stall/flush/forward controls; the
// hazard controller is the slave.
interface pipe_hazard_ctrl_if;
  // decode stage
  logic [4:0]  rs1d;
  logic [4:0]  rs2d;
  logic        use_rs1d;
  logic        use_rs2d;
  // execute stage
  logic [4:0]  rs1e;
  logic [4:0]  rs2e;
  logic [4:0]  rde;
  logic        reg_wee;
  logic [1:0]  wb_ctre;
  logic        branch_taken_e;
  // memory / writeback stages
  logic [4:0]  rdm;
  logic [4:0]  rdw;
  logic        reg_wem;
  logic        reg_wew;
  logic        dmem_req;
  logic        dmem_ready;
  // controls back to the pipeline
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        stall_m;
  logic        flush_d;
  logic        flush_e;
  logic [1:0]  fwd_a_e;
  logic [1:0]  fwd_b_e;
  logic        mem_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output rs1d, rs2d, use_rs1d, use_rs2d,
    output rs1e, rs2e, rde, reg_wee, wb_ctre, branch_taken_e,
    output rdm, rdw, reg_wem, reg_wew, dmem_req, dmem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
    input  fwd_a_e, fwd_b_e, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1d, rs2d, use_rs1d, use_rs2d,
    input  rs1e, rs2e, rde, reg_wee, wb_ctre, branch_taken_e,
    input  rdm, rdw, reg_wem, reg_wew, dmem_req, dmem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
    output fwd_a_e, fwd_b_e, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one ALU source: the newer MEM-stage result
// wins over the WB-stage result; x0 is never forwarded.
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rdm_i,
  input  logic       reg_wem_i,
  input  logic [4:0] rdw_i,
  input  logic       reg_wew_i,
  output logic [1:0] fwd_o
);

  // Pick the youngest in-flight producer of rs_i
  always_comb begin
    fwd_o = FWD_RF;
    if (reg_wem_i && reg_match(rdm_i, rs_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_wew_i && reg_match(rdw_i, rs_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, branch flushes, load-use
// interlock, operand forwarding, memory timeout flag and optional
// performance counters (enabled by defining PIPE_HAZARD_PERF_EN; without it
// stall_cnt/flush_cnt read as constant zero).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic mem_stall;
  logic branch_flush;
  logic load_use_raw;
  logic load_use;
  logic stall_fd;
  logic flush_any;

  // A load in EX whose destination is read by the instruction in decode.
  assign load_use_raw = (hz.wb_ctre == WB_MEM) && hz.reg_wee &&
                        ((hz.use_rs1d && reg_match(hz.rde, hz.rs1d)) ||
                         (hz.use_rs2d && reg_match(hz.rde, hz.rs2d)));

  // The completion cycle (dmem_ready=1) is not stalled so the MEM stage can
  // capture the returned data and the pipeline advances on that same edge.
  assign mem_stall = (state_q == ST_MEM_WAIT) ? !hz.dmem_ready
                                              : (hz.dmem_req && !hz.dmem_ready);

  // Priority: memory stall > branch > load-use. A branch held in EX during
  // a memory stall simply takes effect on the first unstalled cycle.
  assign branch_flush = hz.branch_taken_e && !mem_stall;
  assign load_use     = load_use_raw && !mem_stall && !hz.branch_taken_e;

  assign stall_fd  = mem_stall || load_use;
  assign flush_any = branch_flush || load_use;

  assign hz.stall_f = stall_fd;
  assign hz.stall_d = stall_fd;
  assign hz.stall_e = mem_stall;
  assign hz.stall_m = mem_stall;
  assign hz.flush_d = branch_flush;
  assign hz.flush_e = flush_any;
  assign hz.mem_err = mem_err_q;

  pipe_fwd_unit u_fwd_a (
    .rs_i      (hz.rs1e),
    .rdm_i     (hz.rdm),
    .reg_wem_i (hz.reg_wem),
    .rdw_i     (hz.rdw),
    .reg_wew_i (hz.reg_wew),
    .fwd_o     (hz.fwd_a_e)
  );

  pipe_fwd_unit u_fwd_b (
    .rs_i      (hz.rs2e),
    .rdm_i     (hz.rdm),
    .reg_wem_i (hz.reg_wem),
    .rdw_i     (hz.rdw),
    .reg_wew_i (hz.reg_wew),
    .fwd_o     (hz.fwd_b_e)
  );

  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next state: wait counter saturates so a very long stall cannot wrap it
  // back below the timeout; the FSM keeps waiting after a timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (hz.dmem_req && !hz.dmem_ready) begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (wait_cnt_d >= WAIT_LIMIT) begin
            mem_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counter increments; natural 32-bit wrap
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_fd) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (branch_flush || flush_any) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4. Expected values
// are hand-computed; counter expectations follow PIPE_HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_stall;
  int   exp_flush;

  pipe_hazard_ctrl_if hz_if ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz_if.rs1d = 5'd0;  hz_if.rs2d = 5'd0;
    hz_if.use_rs1d = 1'b0; hz_if.use_rs2d = 1'b0;
    hz_if.rs1e = 5'd0;  hz_if.rs2e = 5'd0; hz_if.rde = 5'd0;
    hz_if.reg_wee = 1'b0; hz_if.wb_ctre = WB_ALU;
    hz_if.branch_taken_e = 1'b0;
    hz_if.rdm = 5'd0; hz_if.rdw = 5'd0;
    hz_if.reg_wem = 1'b0; hz_if.reg_wew = 1'b0;
    hz_if.dmem_req = 1'b0; hz_if.dmem_ready = 1'b0;
  endtask

  task automatic set_load_use_rs1(input logic [4:0] r);
    hz_if.wb_ctre = WB_MEM; hz_if.reg_wee = 1'b1;
    hz_if.rde = r; hz_if.rs1d = r; hz_if.use_rs1d = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; exp_stall = 0; exp_flush = 0;
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;

    // reset state
    chk("rst_mem_err", 32'(hz_if.mem_err), 32'd0);
    chk("rst_stall_cnt", hz_if.stall_cnt, 32'd0);
    chk("rst_flush_cnt", hz_if.flush_cnt, 32'd0);
    chk("rst_stall_m", 32'(hz_if.stall_m), 32'd0);
    cyc();

    // load-use on rs1
    set_load_use_rs1(5'd5); #1;
    chk("lu_stall_f", 32'(hz_if.stall_f), 32'd1);
    chk("lu_stall_d", 32'(hz_if.stall_d), 32'd1);
    chk("lu_flush_e", 32'(hz_if.flush_e), 32'd1);
    chk("lu_flush_d", 32'(hz_if.flush_d), 32'd0);
    chk("lu_stall_e", 32'(hz_if.stall_e), 32'd0);
    cyc(); exp_stall++; exp_flush++;

    // bubble in EX afterwards: no hazard
    clr(); #1;
    chk("lu_after_stall_f", 32'(hz_if.stall_f), 32'd0);
    chk("lu_after_flush_e", 32'(hz_if.flush_e), 32'd0);
    chk("lu_stall_cnt", hz_if.stall_cnt, cnt_exp(exp_stall));
    chk("lu_flush_cnt", hz_if.flush_cnt, cnt_exp(exp_flush));
    cyc();

    // match but source not read
    set_load_use_rs1(5'd5); hz_if.use_rs1d = 1'b0; #1;
    chk("lu_unused_src", 32'(hz_if.stall_f), 32'd0);
    cyc();

    // x0 destination never interlocks
    set_load_use_rs1(5'd0); #1;
    chk("lu_rd0", 32'(hz_if.stall_f), 32'd0);
    cyc();

    // non-load producer does not interlock
    set_load_use_rs1(5'd5); hz_if.wb_ctre = WB_ALU; #1;
    chk("lu_not_load", 32'(hz_if.stall_f), 32'd0);
    cyc();

    // load-use on rs2
    clr();
    hz_if.wb_ctre = WB_MEM; hz_if.reg_wee = 1'b1;
    hz_if.rde = 5'd9; hz_if.rs2d = 5'd9; hz_if.use_rs2d = 1'b1; #1;
    chk("lu2_stall_f", 32'(hz_if.stall_f), 32'd1);
    chk("lu2_flush_e", 32'(hz_if.flush_e), 32'd1);
    cyc(); exp_stall++; exp_flush++;

    // branch together with load-use: flush only
    hz_if.branch_taken_e = 1'b1; #1;
    chk("br_lu_flush_d", 32'(hz_if.flush_d), 32'd1);
    chk("br_lu_flush_e", 32'(hz_if.flush_e), 32'd1);
    chk("br_lu_stall_f", 32'(hz_if.stall_f), 32'd0);
    chk("br_lu_stall_d", 32'(hz_if.stall_d), 32'd0);
    cyc(); exp_flush++;
    clr(); #1;
    chk("br_flush_cnt", hz_if.flush_cnt, cnt_exp(exp_flush));
    chk("br_stall_cnt", hz_if.stall_cnt, cnt_exp(exp_stall));
    cyc();

    // forwarding
    hz_if.rdm = 5'd7; hz_if.rdw = 5'd7; hz_if.rs1e = 5'd7; hz_if.rs2e = 5'd7;
    hz_if.reg_wem = 1'b1; hz_if.reg_wew = 1'b1; #1;
    chk("fwd_a_mem", 32'(hz_if.fwd_a_e), 32'(2'b10));
    chk("fwd_b_mem", 32'(hz_if.fwd_b_e), 32'(2'b10));
    hz_if.rdm = 5'd0; #1;
    chk("fwd_a_wb", 32'(hz_if.fwd_a_e), 32'(2'b01));
    hz_if.rdm = 5'd7; hz_if.reg_wem = 1'b0; #1;
    chk("fwd_a_wem0", 32'(hz_if.fwd_a_e), 32'(2'b01));
    cyc();
    hz_if.reg_wew = 1'b0; #1;
    chk("fwd_a_rf", 32'(hz_if.fwd_a_e), 32'(2'b00));
    hz_if.rdm = 5'd0; hz_if.rdw = 5'd0; hz_if.rs1e = 5'd0; hz_if.rs2e = 5'd0;
    hz_if.reg_wem = 1'b1; hz_if.reg_wew = 1'b1; #1;
    chk("fwd_a_x0", 32'(hz_if.fwd_a_e), 32'(2'b00));
    chk("fwd_b_x0", 32'(hz_if.fwd_b_e), 32'(2'b00));
    hz_if.rs2e = 5'd3; hz_if.rdw = 5'd3; hz_if.rdm = 5'd4; #1;
    chk("fwd_b_wb", 32'(hz_if.fwd_b_e), 32'(2'b01));
    chk("fwd_a_nomatch", 32'(hz_if.fwd_a_e), 32'(2'b00));
    cyc();

    // memory stall: 3 stalled cycles, then completion
    clr(); hz_if.dmem_req = 1'b1; #1;
    chk("ms_stall_f", 32'(hz_if.stall_f), 32'd1);
    chk("ms_stall_d", 32'(hz_if.stall_d), 32'd1);
    chk("ms_stall_e", 32'(hz_if.stall_e), 32'd1);
    chk("ms_stall_m", 32'(hz_if.stall_m), 32'd1);
    chk("ms_flush_e", 32'(hz_if.flush_e), 32'd0);
    cyc(); exp_stall++;
    chk("ms_wait1_stall_m", 32'(hz_if.stall_m), 32'd1);
    cyc(); exp_stall++;
    hz_if.branch_taken_e = 1'b1; set_load_use_rs1(5'd5); #1;
    chk("ms_br_suppr_d", 32'(hz_if.flush_d), 32'd0);
    chk("ms_br_suppr_e", 32'(hz_if.flush_e), 32'd0);
    chk("ms_wait2_stall_m", 32'(hz_if.stall_m), 32'd1);
    cyc(); exp_stall++;
    hz_if.dmem_ready = 1'b1; #1;
    chk("ms_done_stall_m", 32'(hz_if.stall_m), 32'd0);
    chk("ms_done_stall_f", 32'(hz_if.stall_f), 32'd0);
    chk("ms_done_flush_d", 32'(hz_if.flush_d), 32'd1);
    chk("ms_done_flush_e", 32'(hz_if.flush_e), 32'd1);
    cyc(); exp_flush++;
    clr(); #1;
    chk("ms_run_stall_m", 32'(hz_if.stall_m), 32'd0);
    chk("ms_stall_cnt", hz_if.stall_cnt, cnt_exp(exp_stall));
    chk("ms_flush_cnt", hz_if.flush_cnt, cnt_exp(exp_flush));

    // timeout: ready held low
    hz_if.dmem_req = 1'b1;
    cyc(); exp_stall++;
    cyc(); exp_stall++;
    cyc(); exp_stall++;
    cyc(); exp_stall++;
    chk("to_wait3_err", 32'(hz_if.mem_err), 32'd0);
    cyc(); exp_stall++;
    chk("to_wait4_err", 32'(hz_if.mem_err), 32'd1);
    chk("to_wait4_stall", 32'(hz_if.stall_m), 32'd1);
    chk("to_stall_cnt", hz_if.stall_cnt, cnt_exp(exp_stall));
    cyc();
    chk("to_err_sticky", 32'(hz_if.mem_err), 32'd1);
    chk("to_still_wait", 32'(hz_if.stall_m), 32'd1);

    // reset mid-wait
    rst = 1'b1; clr();
    cyc();
    rst = 1'b0; exp_stall = 0; exp_flush = 0; #1;
    chk("rst2_mem_err", 32'(hz_if.mem_err), 32'd0);
    chk("rst2_state_run", 32'(hz_if.stall_m), 32'd0);
    chk("rst2_stall_cnt", hz_if.stall_cnt, 32'd0);
    chk("rst2_flush_cnt", hz_if.flush_cnt, 32'd0);
    hz_if.dmem_req = 1'b1; #1;
    chk("rst2_follow", 32'(hz_if.stall_f), 32'd1);
    cyc(); exp_stall++;
    cyc(); exp_stall++;
    chk("rst2_wait_cleared", 32'(hz_if.mem_err), 32'd0);
    hz_if.dmem_ready = 1'b1; #1;
    chk("rst2_done", 32'(hz_if.stall_m), 32'd0);
    cyc();
    clr(); #1;
    chk("rst2_stall_cnt2", hz_if.stall_cnt, cnt_exp(exp_stall));

`ifdef PIPE_HAZARD_PERF_EN
    // stall counter wrap
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("wrap_pre", hz_if.stall_cnt, 32'hFFFF_FFFF);
    hz_if.dmem_req = 1'b1;
    cyc();
    chk("wrap_post", hz_if.stall_cnt, 32'd0);
    hz_if.dmem_ready = 1'b1;
    cyc();
    clr();
`else
    chk("noperf_stall_cnt", hz_if.stall_cnt, 32'd0);
    chk("noperf_flush_cnt", hz_if.flush_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: max consecutive MEM_WAIT cycles before mem_err sets.
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rs1d, rs2d  in  5 each  decode-stage source registers.
REQ-005 use_rs1d, use_rs2d  in  1 each  decode instruction reads rs1/rs2.
REQ-006 rs1e, rs2e, rde  in  5 each  EX-stage source and destination registers.
REQ-007 reg_wee  in  1  EX register write enable; wb_ctre  in  2  EX writeback select, WB_MEM = load.
REQ-008 rdm, rdw  in  5 each; reg_wem, reg_wew  in  1 each  MEM/WB destinations and write enables.
REQ-009 branch_taken_e  in  1  EX resolved redirect (branch or jalx).
REQ-010 dmem_req, dmem_ready  in  1 each  data-memory request from MEM and completion.
REQ-011 stall_f, stall_d, stall_e, stall_m  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM registers.
REQ-012 flush_d, flush_e  out  1 each  load zeros (bubble) into IF/ID, ID/EX.
REQ-013 fwd_a_e, fwd_b_e  out  2 each  ALU operand source: 00 regfile, 01 WB, 10 MEM.
REQ-014 mem_err  out  1  sticky memory timeout flag.
REQ-015 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-016 FSM states RUN and MEM_WAIT; RUN->MEM_WAIT when dmem_req && !dmem_ready; MEM_WAIT->RUN on cycle dmem_ready=1.
REQ-017 In MEM_WAIT, and in RUN when dmem_req && !dmem_ready, all four stall outputs SHALL be 1 and both flushes 0 (combinational, same cycle).
REQ-018 Load-use: wb_ctre==WB_MEM && reg_wee && rde!=0 && ((use_rs1d && rde==rs1d) || (use_rs2d && rde==rs2d)) SHALL assert stall_f, stall_d, flush_e for that cycle only.
REQ-019 branch_taken_e SHALL assert flush_d and flush_e, no stall.
REQ-020 Priority: memory stall > branch flush > load-use; branch with load-use gives flush only.
REQ-021 Branch during memory stall is suppressed; it applies on the first unstalled cycle (EX held, so input persists).
REQ-022 fwd_a_e = 10 if reg_wem && rdm!=0 && rdm==rs1e; else 01 if reg_wew && rdw!=0 && rdw==rs1e; else 00; fwd_b_e same with rs2e.
REQ-023 Wait counter (8+ bits) increments each MEM_WAIT cycle, clears on entering RUN; reaching MEM_TIMEOUT sets mem_err, held until rst; FSM stays in MEM_WAIT.
REQ-024 stall_cnt +1 per cycle with stall_f=1; flush_cnt +1 per cycle with flush_d|flush_e=1; both wrap 2^32-1 -> 0.

Reset
REQ-025 rst SHALL force state RUN, wait counter 0, mem_err 0, stall_cnt 0, flush_cnt 0, next cycle.
REQ-026 rst mid-MEM_WAIT SHALL abandon the wait; combinational outputs follow inputs from the first post-reset cycle.

Configuration
REQ-027 Macro PIPE_HAZARD_PERF_EN defined: counters per REQ-024; undefined: no counter flops, stall_cnt and flush_cnt driven constant 0, ports kept.

Structure
REQ-028 Package pipe_pkg SHALL hold FWD_RF/FWD_WB/FWD_MEM, WB_MEM encoding, FSM state enum.
REQ-029 Forwarding logic SHALL be sub-module pipe_fwd_unit, instantiated once per operand.

Verification
REQ-030 rde=5 load in EX, rs1d=5 use_rs1d=1 -> one cycle stall_f=stall_d=flush_e=1, then all 0.
REQ-031 branch_taken_e=1 with load-use active -> flush_d=flush_e=1, stall_f=0; flush_cnt+1.
REQ-032 dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> stall_m=1 for 3 cycles, RUN on 4th; stall_cnt+3.
REQ-033 rdm=rdw=rs1e=7, both writing -> fwd_a_e=10; rdm=0 -> 01; rd=0 never forwards.
REQ-034 MEM_TIMEOUT=4, dmem_ready held 0 -> mem_err=1 after 4 wait cycles; rst clears mem_err and state.
REQ-035 stall_cnt preloaded to 0xFFFFFFFF via 2^32-1 stalls (or force) + one stall -> 0; without PIPE_HAZARD_PERF_EN counters stay 0.
